spi_rx_framer: RTL and testbench

- Receive front end of the SPI subsystem.
- Samples an external SPI slave bus (mode 0, MSB first) with the system clock and deserializes MOSI into WIDTH-bit words.
- Writes each word into the downstream dual-clock block RAM write port at an auto-incrementing address, starting from 0 each frame.
- Reports per-frame length and error status when chip select is released.

---
 rtl/spi_rx_framer_if.sv | 29 ++
 rtl/spi_rx_framer.sv | 158 +++++++++++++++
 tb/tb_spi_rx_framer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_framer_if.sv
// Bundles the SPI slave pins, the RAM write port and the per-frame status of the
// receive framer. The framer takes the slave modport; whatever drives the bus takes the master.
interface spi_rx_framer_if #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 4
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_dat;
  logic              frame_done;
  logic [AWIDTH:0]   frame_len;
  logic              frame_partial;
  logic              frame_ovf;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  ram_we, ram_addr, ram_dat,
    input  frame_done, frame_len, frame_partial, frame_ovf
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output ram_we, ram_addr, ram_dat,
    output frame_done, frame_len, frame_partial, frame_ovf
  );
endinterface

// File: rtl/spi_rx_framer.sv
// SPI mode-0 receive framer: oversamples the bus with clk, packs MOSI MSB-first into
// words, writes them to RAM from address 0 each frame, and reports frame status.
module spi_rx_framer #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  spi_rx_framer_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH + 1)'(2 ** AWIDTH);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;

  // Bit order: [2] sclk, [1] cs_n, [0] mosi. Every stage resets to 0, so a low
  // cs_n is assumed until proven otherwise and WAIT_IDLE cannot be fooled.
  logic [2:0] raw_in;
  logic [2:0] sync_in;

  assign raw_in = {bus.spi_sclk, bus.spi_cs_n, bus.spi_mosi};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [1:0] stage_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stage_reg <= '0;
        else       stage_reg <= {stage_reg[0], raw_in[gi]};
      end
      assign sync_in[gi] = stage_reg[1];
    end
  endgenerate

  logic sclk_s, cs_n_s, mosi_s;
  assign sclk_s = sync_in[2];
  assign cs_n_s = sync_in[1];
  assign mosi_s = sync_in[0];

  logic sclk_prev_reg;
  logic sclk_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sclk_prev_reg <= 1'b0;
    else       sclk_prev_reg <= sclk_s;
  end

  assign sclk_rise = sclk_s & ~sclk_prev_reg;

  state_t            state_reg, state_next;
  logic [WIDTH-2:0]  shift_reg;
  logic [WIDTH-1:0]  shift_next;
  logic [BW-1:0]     bit_cnt_reg;
  logic [AWIDTH:0]   word_cnt_reg;
  logic              ovf_acc_reg;
  logic              ram_we_reg;
  logic [AWIDTH-1:0] ram_addr_reg;
  logic [WIDTH-1:0]  ram_dat_reg;
  logic [AWIDTH:0]   frame_len_reg;
  logic              frame_partial_reg;
  logic              frame_ovf_reg;

  logic frame_done_c;
  logic clear_c;
  logic shift_en_c;
  logic word_end_c;
  logic can_write_c;
  logic enter_done_c;

  assign shift_next = {shift_reg, mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= WAIT_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_IDLE: if (cs_n_s)  state_next = IDLE;
      IDLE:      if (!cs_n_s) state_next = SHIFT;
      SHIFT:     if (cs_n_s)  state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = WAIT_IDLE;
    endcase
  end

  // Deasserting cs_n wins over a coincident sclk rise: that edge is simply dropped.
  always_comb begin
    frame_done_c = 1'b0;
    clear_c      = 1'b0;
    shift_en_c   = 1'b0;
    enter_done_c = 1'b0;
    case (state_reg)
      IDLE:  clear_c      = 1'b1;
      SHIFT: begin
        enter_done_c = cs_n_s;
        shift_en_c   = !cs_n_s && sclk_rise;
      end
      DONE:  frame_done_c = 1'b1;
      default: ;
    endcase
    word_end_c  = shift_en_c && (bit_cnt_reg == BW'(WIDTH - 1));
    can_write_c = word_cnt_reg < DEPTH;
  end

  // word_cnt saturates at DEPTH so address 0 is never revisited within a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg         <= '0;
      bit_cnt_reg       <= '0;
      word_cnt_reg      <= '0;
      ovf_acc_reg       <= 1'b0;
      ram_we_reg        <= 1'b0;
      ram_addr_reg      <= '0;
      ram_dat_reg       <= '0;
      frame_len_reg     <= '0;
      frame_partial_reg <= 1'b0;
      frame_ovf_reg     <= 1'b0;
    end else begin
      ram_we_reg <= 1'b0;
      if (clear_c) begin
        bit_cnt_reg  <= '0;
        word_cnt_reg <= '0;
        ovf_acc_reg  <= 1'b0;
      end
      if (shift_en_c) begin
        shift_reg <= shift_next[WIDTH-2:0];
        if (word_end_c) begin
          bit_cnt_reg <= '0;
          if (can_write_c) begin
            ram_we_reg   <= 1'b1;
            ram_addr_reg <= word_cnt_reg[AWIDTH-1:0];
            ram_dat_reg  <= shift_next;
            word_cnt_reg <= word_cnt_reg + (AWIDTH + 1)'(1);
          end else begin
            ovf_acc_reg <= 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + BW'(1);
        end
      end
      // Status is latched on the way into DONE so it is already valid while frame_done is high.
      if (enter_done_c) begin
        frame_len_reg     <= word_cnt_reg;
        frame_partial_reg <= (bit_cnt_reg != '0);
        frame_ovf_reg     <= ovf_acc_reg;
      end
    end
  end

  assign bus.ram_we        = ram_we_reg;
  assign bus.ram_addr      = ram_addr_reg;
  assign bus.ram_dat       = ram_dat_reg;
  assign bus.frame_done    = frame_done_c;
  assign bus.frame_len     = frame_len_reg;
  assign bus.frame_partial = frame_partial_reg;
  assign bus.frame_ovf     = frame_ovf_reg;
endmodule

// File: tb/tb_spi_rx_framer.sv
// Directed bench for spi_rx_framer: drives SPI frames with SCLK at clk/8 and checks
// RAM writes and frame status against hand-computed values.
module tb_spi_rx_framer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  spi_rx_framer_if #(.WIDTH(8), .AWIDTH(4)) bus ();

  spi_rx_framer #(.WIDTH(8), .AWIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Passive log of every write and every frame_done cycle, sampled on the falling edge.
  int         we_cnt = 0;
  int         done_cnt = 0;
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_dat_q[$];
  logic [4:0] done_len_q[$];

  always @(negedge clk) begin
    if (bus.ram_we) begin
      we_cnt++;
      wr_addr_q.push_back(bus.ram_addr);
      wr_dat_q.push_back(bus.ram_dat);
    end
    if (bus.frame_done) begin
      done_cnt++;
      done_len_q.push_back(bus.frame_len);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.spi_mosi = b;
    #40 bus.spi_sclk = 1'b1;
    #40 bus.spi_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_frame();
    wr_addr_q.delete();
    wr_dat_q.delete();
    done_len_q.delete();
    bus.spi_cs_n = 1'b0;
    #40;
  endtask

  task automatic end_frame();
    #40 bus.spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input int len, input logic part, input logic ovf);
    check({tag, "_len"}, 32'(bus.frame_len), 32'(len));
    check({tag, "_partial"}, 32'(bus.frame_partial), 32'(part));
    check({tag, "_ovf"}, 32'(bus.frame_ovf), 32'(ovf));
  endtask

  initial begin
    int we0, done0;
    logic [7:0] exp1[3];
    exp1 = '{8'hA5, 8'h3C, 8'hFF};
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_dat", 32'(bus.ram_dat), 0);
    check("rst_done", 32'(bus.frame_done), 0);
    check_status("rst", 0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: three bytes
    we0 = we_cnt; done0 = done_cnt;
    start_frame();
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
    end_frame();
    check("t1_we_cnt", 32'(we_cnt - we0), 3);
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      check("t1_addr", 32'(wr_addr_q[i]), 32'(i));
      check("t1_dat", 32'(wr_dat_q[i]), 32'(exp1[i]));
    end
    check("t1_done_cnt", 32'(done_cnt - done0), 1);
    check_status("t1", 3, 1'b0, 1'b0);
    check("t1_hold_addr", 32'(bus.ram_addr), 2);
    check("t1_hold_dat", 32'(bus.ram_dat), 32'hFF);

    // 2: twenty bytes overflow a 16-word RAM
    we0 = we_cnt; done0 = done_cnt;
    start_frame();
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    end_frame();
    check("t2_we_cnt", 32'(we_cnt - we0), 16);
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      check("t2_addr", 32'(wr_addr_q[i]), 32'(i));
      check("t2_dat", 32'(wr_dat_q[i]), 32'(i));
    end
    check("t2_done_cnt", 32'(done_cnt - done0), 1);
    check_status("t2", 16, 1'b0, 1'b1);

    // 3: two bytes plus five bits
    we0 = we_cnt; done0 = done_cnt;
    start_frame();
    send_byte(8'h81); send_byte(8'h7E);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    end_frame();
    check("t3_we_cnt", 32'(we_cnt - we0), 2);
    if (wr_dat_q.size() >= 2) begin
      check("t3_dat0", 32'(wr_dat_q[0]), 32'h81);
      check("t3_dat1", 32'(wr_dat_q[1]), 32'h7E);
      check("t3_addr1", 32'(wr_addr_q[1]), 1);
    end
    check("t3_done_cnt", 32'(done_cnt - done0), 1);
    check_status("t3", 2, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check_status("t3_hold", 2, 1'b1, 1'b0);
    check("t3_hold_dat", 32'(bus.ram_dat), 32'h7E);

    // 5: reset mid-frame after 1.5 bytes, released with cs_n still low
    start_frame();
    send_byte(8'hC3);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_addr", 32'(bus.ram_addr), 0);
    check("t5_rst_dat", 32'(bus.ram_dat), 0);
    check_status("t5_rst", 0, 1'b0, 1'b0);
    reset = 1'b0;
    we0 = we_cnt; done0 = done_cnt;
    repeat (3) @(negedge clk);
    send_byte(8'hFF);
    end_frame();
    check("t5_we_cnt", 32'(we_cnt - we0), 0);
    check("t5_done_cnt", 32'(done_cnt - done0), 0);
    we0 = we_cnt; done0 = done_cnt;
    start_frame();
    send_byte(8'h5A);
    end_frame();
    check("t5b_we_cnt", 32'(we_cnt - we0), 1);
    if (wr_dat_q.size() >= 1) begin
      check("t5b_addr", 32'(wr_addr_q[0]), 0);
      check("t5b_dat", 32'(wr_dat_q[0]), 32'h5A);
    end
    check("t5b_done_cnt", 32'(done_cnt - done0), 1);
    check_status("t5b", 1, 1'b0, 1'b0);

    // 4: empty frame
    we0 = we_cnt; done0 = done_cnt;
    start_frame();
    end_frame();
    check("t4_we_cnt", 32'(we_cnt - we0), 0);
    check("t4_done_cnt", 32'(done_cnt - done0), 1);
    check_status("t4", 0, 1'b0, 1'b0);

    // 6: back-to-back frames, cs_n high for only two clocks in between
    we0 = we_cnt; done0 = done_cnt;
    start_frame();
    send_byte(8'h11);
    #40 bus.spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.spi_cs_n = 1'b0;
    #40;
    send_byte(8'h22); send_byte(8'h33);
    end_frame();
    check("t6_we_cnt", 32'(we_cnt - we0), 3);
    if (wr_dat_q.size() >= 3) begin
      check("t6_addr0", 32'(wr_addr_q[0]), 0);
      check("t6_dat0", 32'(wr_dat_q[0]), 32'h11);
      check("t6_addr1", 32'(wr_addr_q[1]), 0);
      check("t6_dat1", 32'(wr_dat_q[1]), 32'h22);
      check("t6_addr2", 32'(wr_addr_q[2]), 1);
      check("t6_dat2", 32'(wr_dat_q[2]), 32'h33);
    end
    check("t6_done_cnt", 32'(done_cnt - done0), 2);
    if (done_len_q.size() >= 2) begin
      check("t6_len_first", 32'(done_len_q[0]), 1);
      check("t6_len_second", 32'(done_len_q[1]), 2);
    end
    check_status("t6", 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
